// File: rtl/stream_demux2.sv
// rtl/stream_demux2.sv - 1:2 stream demux steering beats into per-channel FIFOs
// Channel FIFO with beat counter; instantiated once per output channel.
module stream_demux2_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop_ready,
    output logic             full,
    output logic             valid,
    output logic [WIDTH-1:0] data,
    output logic [CNT_W-1:0] count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_OCC = DEPTH[PTR_W:0];

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   occ_q, occ_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pop;

    assign full  = (occ_q == FULL_OCC);
    assign valid = (occ_q != '0);
    assign data  = mem_q[rd_ptr_q];
    assign count = cnt_q;
    assign pop   = valid & pop_ready;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        cnt_d    = cnt_q;
        if (push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            cnt_d           = cnt_q + CNT_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        // Push and pop together leave occupancy unchanged.
        case ({push, pop})
            2'b10:   occ_d = occ_q + (PTR_W+1)'(1);
            2'b01:   occ_d = occ_q - (PTR_W+1)'(1);
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            cnt_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            cnt_q    <= cnt_d;
        end
    end
endmodule

module stream_demux2 #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             in_sel,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             est_valid,
    output logic [WIDTH-1:0] est_data,
    input  logic             est_ready,
    output logic             rand_valid,
    output logic [WIDTH-1:0] rand_data,
    input  logic             rand_ready,
    output logic [CNT_W-1:0] est_count,
    output logic [CNT_W-1:0] rand_count
);
    logic est_full, rand_full;
    logic est_push, rand_push;

    // Readiness follows the selected channel only; a full channel never takes push-through.
    assign in_ready  = ~rst & ~(in_sel ? rand_full : est_full);
    assign est_push  = in_valid & in_ready & ~in_sel;
    assign rand_push = in_valid & in_ready & in_sel;

    stream_demux2_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) u_est (
        .clk       (clk),
        .rst       (rst),
        .push      (est_push),
        .push_data (in_data),
        .pop_ready (est_ready),
        .full      (est_full),
        .valid     (est_valid),
        .data      (est_data),
        .count     (est_count)
    );

    stream_demux2_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) u_rand (
        .clk       (clk),
        .rst       (rst),
        .push      (rand_push),
        .push_data (in_data),
        .pop_ready (rand_ready),
        .full      (rand_full),
        .valid     (rand_valid),
        .data      (rand_data),
        .count     (rand_count)
    );
endmodule
